// File: rtl/ppl_regwb.sv
// MEM->WB pipeline register: selects/extends the writeback value, registers it,
// keeps the previous writeback one more cycle and counts committed writes.
module ppl_regwb #(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 5,
   parameter int CNT_W       = 16,
   parameter int ZERO_REG_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mWriteReg,
   input  logic              mMem2Reg,
   input  logic              mLink,
   input  logic [1:0]        mLdSize,
   input  logic              mLdSigned,
   input  logic [1:0]        mAddrLo,
   input  logic [REG_AW-1:0] mReg,
   input  logic [DATA_W-1:0] mAlu,
   input  logic [DATA_W-1:0] mMemOut,
   input  logic [DATA_W-1:0] mLinkAddr,
   input  logic              stall,
   input  logic              flush,
   output logic              wWriteReg,
   output logic [REG_AW-1:0] wReg,
   output logic [DATA_W-1:0] wDataImm,
   output logic              pWriteReg,
   output logic [REG_AW-1:0] pReg,
   output logic [DATA_W-1:0] pData,
   output logic [CNT_W-1:0]  wbCount
);

   logic [7:0]        byteLanes [4];
   logic [7:0]        byteSel;
   logic [15:0]       halfSel;
   logic [DATA_W-1:0] loadData;
   logic [DATA_W-1:0] selData;
   logic              effWrite;

   // Little-endian byte lanes of the low load word.
   for (genvar gi = 0; gi < 4; gi++) begin : gLane
      assign byteLanes[gi] = mMemOut[8*gi +: 8];
   end

   always_comb begin
      byteSel = byteLanes[mAddrLo];
      halfSel = mAddrLo[1] ? mMemOut[31:16] : mMemOut[15:0];
      case (mLdSize)
         2'b01:   loadData = {{(DATA_W-16){mLdSigned & halfSel[15]}}, halfSel};
         2'b10:   loadData = {{(DATA_W-8){mLdSigned & byteSel[7]}}, byteSel};
         default: loadData = mMemOut;
      endcase
      if (mLink)
         selData = mLinkAddr;
      else if (mMem2Reg)
         selData = loadData;
      else
         selData = mAlu;
      effWrite = mWriteReg & ~((ZERO_REG_EN != 0) && (mReg == '0));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wWriteReg <= 1'b0;
         wReg      <= '0;
         wDataImm  <= '0;
         pWriteReg <= 1'b0;
         pReg      <= '0;
         pData     <= '0;
         wbCount   <= '0;
      end else if (flush) begin
         // Bubble enters WB; the outgoing write still shifts into p* for forwarding.
         pWriteReg <= wWriteReg;
         pReg      <= wReg;
         pData     <= wDataImm;
         wWriteReg <= 1'b0;
         wReg      <= '0;
         wDataImm  <= '0;
      end else if (!stall) begin
         pWriteReg <= wWriteReg;
         pReg      <= wReg;
         pData     <= wDataImm;
         wWriteReg <= effWrite;
         wReg      <= mReg;
         wDataImm  <= selData;
         if (effWrite)
            wbCount <= wbCount + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_ppl_regwb.sv
// Table-driven bench for ppl_regwb with a reference model feeding an expected-result queue.
module tb_ppl_regwb;

   logic        clk = 1'b0;
   logic        reset, mWriteReg, mMem2Reg, mLink, mLdSigned, stall, flush;
   logic [1:0]  mLdSize, mAddrLo;
   logic [4:0]  mReg;
   logic [31:0] mAlu, mMemOut, mLinkAddr;
   logic        wWriteReg, pWriteReg, wWriteReg2, pWriteReg2;
   logic [4:0]  wReg, pReg, wReg2, pReg2;
   logic [31:0] wDataImm, pData, wDataImm2, pData2;
   logic [15:0] wbCount;
   logic [1:0]  wbCount2;

   always #5 clk = ~clk;

   ppl_regwb dut (
      .clk(clk), .reset(reset), .mWriteReg(mWriteReg), .mMem2Reg(mMem2Reg), .mLink(mLink),
      .mLdSize(mLdSize), .mLdSigned(mLdSigned), .mAddrLo(mAddrLo), .mReg(mReg),
      .mAlu(mAlu), .mMemOut(mMemOut), .mLinkAddr(mLinkAddr), .stall(stall), .flush(flush),
      .wWriteReg(wWriteReg), .wReg(wReg), .wDataImm(wDataImm),
      .pWriteReg(pWriteReg), .pReg(pReg), .pData(pData), .wbCount(wbCount));

   // Narrow-counter instance sharing the same stimulus, for wrap-around checks.
   ppl_regwb #(.CNT_W(2)) dutNarrow (
      .clk(clk), .reset(reset), .mWriteReg(mWriteReg), .mMem2Reg(mMem2Reg), .mLink(mLink),
      .mLdSize(mLdSize), .mLdSigned(mLdSigned), .mAddrLo(mAddrLo), .mReg(mReg),
      .mAlu(mAlu), .mMemOut(mMemOut), .mLinkAddr(mLinkAddr), .stall(stall), .flush(flush),
      .wWriteReg(wWriteReg2), .wReg(wReg2), .wDataImm(wDataImm2),
      .pWriteReg(pWriteReg2), .pReg(pReg2), .pData(pData2), .wbCount(wbCount2));

   typedef struct {
      logic        wr, m2r, link;
      logic [1:0]  sz;
      logic        sgn;
      logic [1:0]  lo;
      logic [4:0]  rd;
      logic [31:0] alu, mem, lnk;
      logic        stl, fl, rst;
      logic        expW;
      logic [4:0]  expReg;
      logic [31:0] expData;
   } vec_t;

   typedef struct {
      logic        w;
      logic [4:0]  r;
      logic [31:0] d;
      logic        pw;
      logic [4:0]  pr;
      logic [31:0] pd;
      logic [15:0] cnt;
   } exp_t;

   vec_t tbl[$];
   exp_t expQ[$];
   int   nChecks = 0;
   int   nPass   = 0;

   logic        mdlW, mdlPW;
   logic [4:0]  mdlR, mdlPR;
   logic [31:0] mdlD, mdlPD;
   logic [15:0] mdlCnt;

   function automatic vec_t mk(input logic wr, m2r, link, input logic [1:0] sz, input logic sgn,
                               input logic [1:0] lo, input logic [4:0] rd,
                               input logic [31:0] alu, mem, lnk,
                               input logic stl, fl, rst, input logic expW,
                               input logic [4:0] expReg, input logic [31:0] expData);
      vec_t v;
      v.wr = wr; v.m2r = m2r; v.link = link; v.sz = sz; v.sgn = sgn; v.lo = lo; v.rd = rd;
      v.alu = alu; v.mem = mem; v.lnk = lnk; v.stl = stl; v.fl = fl; v.rst = rst;
      v.expW = expW; v.expReg = expReg; v.expData = expData;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
      nChecks++;
      if (got === want)
         nPass++;
      else
         $display("FAIL %s txn %0d: got %h expected %h", name, idx, got, want);
   endtask

   task automatic runVec(input vec_t v, input int idx);
      exp_t e;
      exp_t g;
      reset = v.rst; stall = v.stl; flush = v.fl;
      mWriteReg = v.wr; mMem2Reg = v.m2r; mLink = v.link; mLdSize = v.sz; mLdSigned = v.sgn;
      mAddrLo = v.lo; mReg = v.rd; mAlu = v.alu; mMemOut = v.mem; mLinkAddr = v.lnk;
      if (v.rst) begin
         mdlW = 0; mdlR = 0; mdlD = 0; mdlPW = 0; mdlPR = 0; mdlPD = 0; mdlCnt = 0;
      end else if (v.fl) begin
         mdlPW = mdlW; mdlPR = mdlR; mdlPD = mdlD;
         mdlW = 0; mdlR = 0; mdlD = 0;
      end else if (!v.stl) begin
         mdlPW = mdlW; mdlPR = mdlR; mdlPD = mdlD;
         mdlW = v.expW; mdlR = v.expReg; mdlD = v.expData;
         if (v.expW) mdlCnt = mdlCnt + 16'd1;
      end
      e.w = mdlW; e.r = mdlR; e.d = mdlD; e.pw = mdlPW; e.pr = mdlPR; e.pd = mdlPD; e.cnt = mdlCnt;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      g = expQ.pop_front();
      chk("wWriteReg", idx, {31'd0, wWriteReg}, {31'd0, g.w});
      chk("wReg",      idx, {27'd0, wReg},      {27'd0, g.r});
      chk("wDataImm",  idx, wDataImm,           g.d);
      chk("pWriteReg", idx, {31'd0, pWriteReg}, {31'd0, g.pw});
      chk("pReg",      idx, {27'd0, pReg},      {27'd0, g.pr});
      chk("pData",     idx, pData,              g.pd);
      chk("wbCount",   idx, {16'd0, wbCount},   {16'd0, g.cnt});
      chk("wbCount2",  idx, {30'd0, wbCount2},  {30'd0, g.cnt[1:0]});
      $display("txn %0d rst=%0b stl=%0b fl=%0b -> w=%0b r=%0d d=%h p=%0b/%0d/%h cnt=%0d",
               idx, v.rst, v.stl, v.fl, wWriteReg, wReg, wDataImm, pWriteReg, pReg, pData, wbCount);
   endtask

   initial begin
      //              wr m2r lk sz    sg lo    rd     alu           mem           lnk           st fl rs eW eR     eData
      tbl.push_back(mk(1, 1, 0, 2'b10, 1, 2'd2, 5'd3, 32'h0,        32'h1280_3456, 32'h0,       0, 0, 1, 0, 5'd0,  32'h0));
      tbl.push_back(mk(1, 1, 0, 2'b10, 1, 2'd2, 5'd3, 32'h0,        32'h1280_3456, 32'h0,       0, 0, 0, 1, 5'd3,  32'hFFFF_FF80));
      tbl.push_back(mk(1, 1, 0, 2'b01, 0, 2'd2, 5'd4, 32'h0,        32'h8001_0000, 32'h0,       0, 0, 0, 1, 5'd4,  32'h0000_8001));
      tbl.push_back(mk(1, 1, 1, 2'b01, 0, 2'd2, 5'd4, 32'h0,        32'h8001_0000, 32'h0040_0008, 0, 0, 0, 1, 5'd4, 32'h0040_0008));
      tbl.push_back(mk(1, 0, 0, 2'b00, 0, 2'd0, 5'd0, 32'hDEAD,     32'h0,        32'h0,        0, 0, 0, 0, 5'd0,  32'hDEAD));
      tbl.push_back(mk(1, 1, 0, 2'b00, 1, 2'd1, 5'd7, 32'h0,        32'hCAFE_BABE, 32'h0,       0, 0, 0, 1, 5'd7,  32'hCAFE_BABE));
      tbl.push_back(mk(1, 1, 0, 2'b11, 1, 2'd3, 5'd8, 32'h0,        32'h0123_4567, 32'h0,       0, 0, 0, 1, 5'd8,  32'h0123_4567));
      tbl.push_back(mk(1, 1, 0, 2'b10, 0, 2'd1, 5'd9, 32'h0,        32'h1280_3456, 32'h0,       0, 0, 0, 1, 5'd9,  32'h0000_0034));
      tbl.push_back(mk(1, 1, 0, 2'b10, 1, 2'd3, 5'd10, 32'h0,       32'h9200_0000, 32'h0,       0, 0, 0, 1, 5'd10, 32'hFFFF_FF92));
      tbl.push_back(mk(1, 1, 0, 2'b01, 1, 2'd0, 5'd11, 32'h0,       32'h1234_8765, 32'h0,       0, 0, 0, 1, 5'd11, 32'hFFFF_8765));
      tbl.push_back(mk(1, 1, 0, 2'b01, 1, 2'd3, 5'd12, 32'h0,       32'h8765_1234, 32'h0,       0, 0, 0, 1, 5'd12, 32'hFFFF_8765));
      tbl.push_back(mk(1, 0, 0, 2'b10, 1, 2'd0, 5'd13, 32'h55AA_55AA, 32'hFFFF_FFFF, 32'h0,     0, 0, 0, 1, 5'd13, 32'h55AA_55AA));
      tbl.push_back(mk(0, 0, 0, 2'b00, 0, 2'd0, 5'd14, 32'h1,       32'h0,        32'h0,        0, 0, 0, 0, 5'd14, 32'h1));
      // Commit A, two stalled cycles with fresh inputs, then flush+stall.
      tbl.push_back(mk(1, 0, 0, 2'b00, 0, 2'd0, 5'd5, 32'h11,       32'h0,        32'h0,        0, 0, 0, 1, 5'd5,  32'h11));
      tbl.push_back(mk(1, 0, 0, 2'b00, 0, 2'd0, 5'd6, 32'h22,       32'h0,        32'h0,        1, 0, 0, 1, 5'd6,  32'h22));
      tbl.push_back(mk(1, 0, 0, 2'b00, 0, 2'd0, 5'd7, 32'h33,       32'h0,        32'h0,        1, 0, 0, 1, 5'd7,  32'h33));
      tbl.push_back(mk(1, 0, 0, 2'b00, 0, 2'd0, 5'd8, 32'h44,       32'h0,        32'h0,        1, 1, 0, 1, 5'd8,  32'h44));
      tbl.push_back(mk(1, 0, 0, 2'b00, 0, 2'd0, 5'd9, 32'h55,       32'h0,        32'h0,        0, 1, 0, 1, 5'd9,  32'h55));
      // Four enabled commits drive the 2-bit counter through its wrap.
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1, 0, 0, 2'b00, 0, 2'd0, 5'(16 + i), 32'(32'hA0 + i), 32'h0, 32'h0, 0, 0, 0, 1, 5'(16 + i), 32'(32'hA0 + i)));
      // Reset during stall, and during flush, with valid inputs; then resume.
      tbl.push_back(mk(1, 0, 0, 2'b00, 0, 2'd0, 5'd21, 32'h66,      32'h0,        32'h0,        1, 0, 1, 1, 5'd21, 32'h66));
      tbl.push_back(mk(1, 0, 0, 2'b00, 0, 2'd0, 5'd22, 32'h77,      32'h0,        32'h0,        0, 0, 0, 1, 5'd22, 32'h77));
      tbl.push_back(mk(1, 0, 0, 2'b00, 0, 2'd0, 5'd23, 32'h88,      32'h0,        32'h0,        0, 1, 1, 1, 5'd23, 32'h88));
      tbl.push_back(mk(1, 1, 1, 2'b10, 1, 2'd3, 5'd24, 32'h0,       32'hFF00_0000, 32'h1234_5678, 0, 0, 0, 1, 5'd24, 32'h1234_5678));
      tbl.push_back(mk(1, 1, 0, 2'b10, 1, 2'd0, 5'd25, 32'h0,       32'h0000_007F, 32'h0,       0, 0, 0, 1, 5'd25, 32'h0000_007F));

      for (int i = 0; i < tbl.size(); i++)
         runVec(tbl[i], i);

      nChecks++;
      if (expQ.size() == 0)
         nPass++;
      else
         $display("FAIL queue_drain: got %0d entries expected 0", expQ.size());

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
